cva6_ptw_sv32: RTL and testbench

Sv32 hardware page-table walker that services TLB misses for the CV32A6 MMU and produces the single-cycle refill update consumed by the Sv32 TLB. On a miss it fetches the level-1 and, if needed, level-0 PTE through a simple request/grant/rvalid memory port, checks each PTE, and either pulses a TLB update or reports a page fault. One walk is in flight at a time.

---
 rtl/cva6_ptw_sv32.sv | 131 +++++++++++++
 tb/tb_cva6_ptw_sv32.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_ptw_sv32.sv
// rtl/cva6_ptw_sv32.sv - Sv32 page-table walker producing TLB refills or page faults
// One walk in flight; flush aborts it and any already-granted read is drained.
module cva6_ptw_sv32 #(
   parameter int unsigned ASID_WIDTH = 9
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic [21:0]           satp_ppn_i,
   input  logic                  miss_valid_i,
   input  logic [31:0]           miss_vaddr_i,
   input  logic [ASID_WIDTH-1:0] miss_asid_i,
   output logic                  busy_o,
   output logic                  mem_req_o,
   output logic [33:0]           mem_addr_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [31:0]           mem_rdata_i,
   output logic                  update_valid_o,
   output logic [19:0]           update_vpn_o,
   output logic [ASID_WIDTH-1:0] update_asid_o,
   output logic                  update_is_4M_o,
   output logic [31:0]           update_content_o,
   output logic                  fault_o,
   output logic [31:0]           fault_vaddr_o
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT_RD, DONE, FLUSH_DRAIN} state_e;

   state_e                state_q;
   logic                  lvl_q;
   logic                  fault_q;
   logic                  is_4m_q;
   logic [31:0]           vaddr_q;
   logic [31:0]           content_q;
   logic [ASID_WIDTH-1:0] asid_q;
   logic [33:0]           addr_q;

   logic pte_bad;
   logic pte_ptr;
   logic leaf_bad;

   // Leaf rejection: misaligned superpage, or A clear since A/D are never set by hardware.
   always_comb begin
      pte_bad  = ~mem_rdata_i[0] | (~mem_rdata_i[1] & mem_rdata_i[2]);
      pte_ptr  = ~mem_rdata_i[1] & ~mem_rdata_i[3];
      leaf_bad = (lvl_q & (mem_rdata_i[19:10] != 10'd0)) | ~mem_rdata_i[6];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         lvl_q     <= 1'b0;
         fault_q   <= 1'b0;
         is_4m_q   <= 1'b0;
         vaddr_q   <= '0;
         content_q <= '0;
         asid_q    <= '0;
         addr_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (miss_valid_i) begin
                  vaddr_q <= miss_vaddr_i;
                  asid_q  <= miss_asid_i;
                  lvl_q   <= 1'b1;
                  addr_q  <= {satp_ppn_i, miss_vaddr_i[31:22], 2'b00};
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (flush_i) begin
                  state_q <= mem_gnt_i ? FLUSH_DRAIN : IDLE;
               end else if (mem_gnt_i) begin
                  state_q <= WAIT_RD;
               end
            end
            WAIT_RD: begin
               if (flush_i) begin
                  state_q <= mem_rvalid_i ? IDLE : FLUSH_DRAIN;
               end else if (mem_rvalid_i) begin
                  if (pte_bad) begin
                     fault_q <= 1'b1;
                     state_q <= DONE;
                  end else if (pte_ptr) begin
                     if (lvl_q) begin
                        lvl_q   <= 1'b0;
                        addr_q  <= {mem_rdata_i[31:10], vaddr_q[21:12], 2'b00};
                        state_q <= REQ;
                     end else begin
                        fault_q <= 1'b1;
                        state_q <= DONE;
                     end
                  end else if (leaf_bad) begin
                     fault_q <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     fault_q   <= 1'b0;
                     content_q <= mem_rdata_i;
                     is_4m_q   <= lvl_q;
                     state_q   <= DONE;
                  end
               end
            end
            DONE: begin
               fault_q <= 1'b0;
               state_q <= IDLE;
            end
            FLUSH_DRAIN: begin
               if (mem_rvalid_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o           = (state_q != IDLE);
   assign mem_req_o        = (state_q == REQ);
   assign mem_addr_o       = addr_q;
   // A flush landing in DONE still kills the pulse.
   assign update_valid_o   = (state_q == DONE) & ~fault_q & ~flush_i;
   assign fault_o          = (state_q == DONE) & fault_q & ~flush_i;
   assign update_vpn_o     = vaddr_q[31:12];
   assign update_asid_o    = asid_q;
   assign update_is_4M_o   = is_4m_q;
   assign update_content_o = content_q;
   assign fault_vaddr_o    = vaddr_q;

endmodule

// File: tb/tb_cva6_ptw_sv32.sv
// tb/tb_cva6_ptw_sv32.sv - randomized bench for cva6_ptw_sv32 against a page-table model
module tb_cva6_ptw_sv32;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic [21:0] satp_ppn_i = '0;
   logic        miss_valid_i = 1'b0;
   logic [31:0] miss_vaddr_i = '0;
   logic [8:0]  miss_asid_i = '0;
   logic        busy_o;
   logic        mem_req_o;
   logic [33:0] mem_addr_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        update_valid_o;
   logic [19:0] update_vpn_o;
   logic [8:0]  update_asid_o;
   logic        update_is_4M_o;
   logic [31:0] update_content_o;
   logic        fault_o;
   logic [31:0] fault_vaddr_o;

   int n_chk = 0;
   int n_pass = 0;

   logic [31:0] mem [logic [33:0]];

   cva6_ptw_sv32 #(.ASID_WIDTH(9)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .satp_ppn_i(satp_ppn_i),
      .miss_valid_i(miss_valid_i), .miss_vaddr_i(miss_vaddr_i), .miss_asid_i(miss_asid_i),
      .busy_o(busy_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .update_valid_o(update_valid_o), .update_vpn_o(update_vpn_o),
      .update_asid_o(update_asid_o), .update_is_4M_o(update_is_4M_o),
      .update_content_o(update_content_o), .fault_o(fault_o), .fault_vaddr_o(fault_vaddr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] mem_rd(input logic [33:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0;
   endfunction

   function automatic logic [31:0] rand_pte(input int kind);
      logic [31:0] p;
      p = $urandom;
      case (kind)
         0: begin p[0] = 1'b1; p[1] = 1'b1; p[6] = 1'b1; p[19:10] = '0; end
         1: p[3:0] = 4'b0001;
         2: p[0] = 1'b0;
         3: begin p[0] = 1'b1; p[1] = 1'b1; p[6] = 1'b0; end
         default: begin p[0] = 1'b1; p[3] = 1'b1; p[6] = 1'b1; end
      endcase
      return p;
   endfunction

   task automatic run_walk(input string tag, input logic [31:0] va, input logic [8:0] asid,
                           input int gw, input int rw, input int flush_at);
      logic [33:0] a1, a2;
      logic [31:0] p1, p2, leaf;
      int levels, done_cyc, cyc, grants, req_cnt, rv_cnt, pulses, pc;
      bit exp_fault, exp_4m, flushed, pending, done;
      logic [33:0] rd_addr;
      logic g_fault, g_4m;
      logic [19:0] g_vpn;
      logic [8:0] g_asid;
      logic [31:0] g_cont, g_fva;

      // Reference walk computed straight from the Sv32 rules on the memory image.
      a1 = {satp_ppn_i, va[31:22], 2'b00};
      p1 = mem_rd(a1);
      a2 = '0; levels = 1; exp_fault = 0; exp_4m = 1; leaf = p1;
      if (!p1[0] || (!p1[1] && p1[2])) exp_fault = 1;
      else if (!p1[1] && !p1[3]) begin
         levels = 2; exp_4m = 0;
         a2 = {p1[31:10], va[21:12], 2'b00};
         p2 = mem_rd(a2);
         leaf = p2;
         if (!p2[0] || (!p2[1] && p2[2]) || (!p2[1] && !p2[3]) || !p2[6]) exp_fault = 1;
      end else if (p1[19:10] != 10'd0 || !p1[6]) exp_fault = 1;
      done_cyc = 1 + levels * (2 + gw + rw);
      flushed = (flush_at >= 1) && (flush_at <= done_cyc);

      @(negedge clk_i);
      miss_valid_i = 1'b1; miss_vaddr_i = va; miss_asid_i = asid;
      @(posedge clk_i);
      cyc = 1; grants = 0; req_cnt = 0; rv_cnt = -1; pending = 0; pulses = 0; done = 0;
      pc = 0; g_fault = 0; g_4m = 0; g_vpn = '0; g_asid = '0; g_cont = '0; g_fva = '0;
      while (!done) begin
         @(negedge clk_i);
         flush_i = (cyc == flush_at);
         #1;
         if (update_valid_o || fault_o) begin
            pulses++;
            if (pulses == 1) begin
               pc = cyc; g_fault = fault_o; g_4m = update_is_4M_o; g_vpn = update_vpn_o;
               g_asid = update_asid_o; g_cont = update_content_o; g_fva = fault_vaddr_o;
            end
         end
         if (cyc == 1) begin
            chk({tag, "_busy1"}, busy_o, 1);
            chk({tag, "_req1"}, mem_req_o, 1);
         end
         if (mem_req_o) chk({tag, "_addr"}, mem_addr_o, (grants == 0) ? a1 : a2);
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
         if (!busy_o && !pending) begin
            done = 1; miss_valid_i = 1'b0; flush_i = 1'b0;
         end else if (cyc > 150) begin
            chk({tag, "_timeout"}, 1, 0);
            done = 1; miss_valid_i = 1'b0; flush_i = 1'b0;
         end else begin
            if (rv_cnt == 0) begin
               mem_rvalid_i = 1'b1; mem_rdata_i = mem_rd(rd_addr); rv_cnt = -1; pending = 0;
            end else if (rv_cnt > 0) rv_cnt--;
            if (mem_req_o) begin
               if (req_cnt == gw) begin
                  mem_gnt_i = 1'b1; rd_addr = mem_addr_o; rv_cnt = rw; pending = 1;
                  req_cnt = 0; grants++;
               end else req_cnt++;
            end else req_cnt = 0;
            miss_valid_i = busy_o ? 1'($urandom_range(0, 1)) : 1'b0;
            miss_vaddr_i = $urandom; miss_asid_i = 9'($urandom);
            @(posedge clk_i);
            cyc++;
         end
      end

      chk({tag, "_pulses"}, pulses, flushed ? 0 : 1);
      if (!flushed && pulses > 0) begin
         chk({tag, "_cycle"}, pc, done_cyc);
         chk({tag, "_isfault"}, g_fault, exp_fault);
         if (exp_fault) chk({tag, "_fva"}, g_fva, va);
         else begin
            chk({tag, "_4m"}, g_4m, exp_4m);
            chk({tag, "_vpn"}, g_vpn, va[31:12]);
            chk({tag, "_asid"}, g_asid, asid);
            chk({tag, "_content"}, g_cont, leaf);
            chk({tag, "_hold"}, update_content_o, leaf);
         end
      end
   endtask

   initial begin
      logic [31:0] va;
      logic [33:0] a1, a2;
      logic [31:0] p1;
      int gw, rw, fa;

      #2;
      chk("rst_busy", busy_o, 0);
      chk("rst_req", mem_req_o, 0);
      chk("rst_upd", update_valid_o, 0);
      chk("rst_fault", fault_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_content", update_content_o, 0);
      chk("rst_fva", fault_vaddr_o, 0);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;

      satp_ppn_i = 22'h00100;
      mem.delete(); mem[34'h0_00100804] = 32'h200000CF;
      run_walk("w4m", 32'h80400123, 9'h05A, 0, 0, 0);
      mem.delete(); mem[34'h0_00100804] = 32'h00040001; mem[34'h0_00100158] = 32'h123450C7;
      run_walk("w4k", 32'h80456123, 9'h123, 0, 0, 0);
      mem.delete();
      run_walk("f_zero", 32'h80400123, 9'h001, 0, 0, 0);
      mem[34'h0_00100804] = 32'h200004CF;
      run_walk("f_misal", 32'h80400123, 9'h002, 0, 0, 0);
      mem[34'h0_00100804] = 32'h2000008F;
      run_walk("f_noa", 32'h80400123, 9'h003, 0, 0, 0);
      mem.delete(); mem[34'h0_00100804] = 32'h00040001; mem[34'h0_00100158] = 32'h00000001;
      run_walk("f_ptr0", 32'h80456123, 9'h004, 1, 1, 0);
      mem.delete(); mem[34'h0_00100804] = 32'h200000CF;
      run_walk("flush_rd", 32'h80400123, 9'h006, 0, 3, 3);
      run_walk("after_fl", 32'h80400123, 9'h007, 0, 0, 0);
      run_walk("bp_gnt4", 32'h80400123, 9'h008, 4, 0, 0);
      run_walk("flush_req", 32'h80400123, 9'h009, 2, 0, 1);

      for (int i = 0; i < 40; i++) begin
         satp_ppn_i = 22'($urandom);
         va = $urandom;
         mem.delete();
         a1 = {satp_ppn_i, va[31:22], 2'b00};
         p1 = rand_pte($urandom_range(0, 4));
         mem[a1] = p1;
         if (p1[3:0] == 4'b0001) begin
            a2 = {p1[31:10], va[21:12], 2'b00};
            mem[a2] = rand_pte($urandom_range(0, 4));
         end
         gw = $urandom_range(0, 3);
         rw = $urandom_range(0, 3);
         fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1 + 2 * (2 + gw + rw)) : 0;
         run_walk($sformatf("rnd%0d", i), va, 9'($urandom), gw, rw, fa);
      end

      // Asynchronous reset in the middle of a walk.
      @(negedge clk_i);
      miss_valid_i = 1'b1; miss_vaddr_i = 32'h12345678;
      @(negedge clk_i);
      miss_valid_i = 1'b0;
      chk("arst_pre_busy", busy_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_busy", busy_o, 0);
      chk("arst_req", mem_req_o, 0);
      chk("arst_fva", fault_vaddr_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
